// File: rtl/ultrasonic_pkg.sv
// Shared types and helpers for the HC-SR04 trigger/echo front end.
package ultrasonic_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_TRIG      = 5'b00010,
        ST_WAIT_RISE = 5'b00100,
        ST_WAIT_FALL = 5'b01000,
        ST_HOLDOFF   = 5'b10000
    } state_e;

    // Product is formed in 64 bits; callers keep the result within CYC_W.
    function automatic logic [CYC_W-1:0] us_to_cyc(input int unsigned us,
                                                   input int unsigned clk_per_us);
        return CYC_W'(64'(us) * 64'(clk_per_us));
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous pin inputs, cleared on reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ultrasonic_trig.sv
// HC-SR04 initiator: periodic TRIG pulse, synchronised ECHO width measurement,
// done/timeout strobes registered so they coincide with the echo_cycles update.
module ultrasonic_trig
    import ultrasonic_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 50,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned PERIOD_US  = 60000,
    parameter int unsigned RISE_TO_US = 1000,
    parameter int unsigned FALL_TO_US = 38000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_echo_in,
    output logic             o_trig,
    output logic             o_busy,
    output logic [CYC_W-1:0] o_echo_cycles,
    output logic             o_done,
    output logic             o_timeout
);

    localparam logic [CYC_W-1:0] TRIG_CYC   = us_to_cyc(TRIG_US, CLK_PER_US);
    localparam logic [CYC_W-1:0] PERIOD_CYC = us_to_cyc(PERIOD_US, CLK_PER_US);
    localparam logic [CYC_W-1:0] RISE_CYC   = us_to_cyc(RISE_TO_US, CLK_PER_US);
    localparam logic [CYC_W-1:0] FALL_CYC   = us_to_cyc(FALL_TO_US, CLK_PER_US);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_echo_s;
    logic             w_done;
    logic             w_timeout;
    logic [CYC_W-1:0] r_cnt;
    logic [CYC_W-1:0] r_per;
    logic [CYC_W-1:0] r_echo_cycles;
    logic             r_done;
    logic             r_timeout;

    sync_2ff u_echo_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_echo_in),
        .o_q   (w_echo_s)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable) w_state_nxt = ST_TRIG;
            end
            ST_TRIG: begin
                if (r_cnt == TRIG_CYC - 1) w_state_nxt = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                // A rising edge on the last allowed cycle still counts.
                if (w_echo_s) begin
                    w_state_nxt = ST_WAIT_FALL;
                end else if (r_cnt == RISE_CYC - 1) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_timeout   = 1'b1;
                end
            end
            ST_WAIT_FALL: begin
                if (!w_echo_s) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_done      = 1'b1;
                end else if (r_cnt == FALL_CYC) begin
                    w_state_nxt = ST_HOLDOFF;
                    w_timeout   = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (r_per == PERIOD_CYC - 1 && !w_echo_s)
                    w_state_nxt = i_enable ? ST_TRIG : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // r_cnt is the per-phase counter; in WAIT_FALL it holds the number of
    // echo-high cycles seen so far, so the edge cycle itself is counted as 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_per         <= '0;
            r_echo_cycles <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_done    <= w_done;
            r_timeout <= w_timeout;
            if (w_done) r_echo_cycles <= r_cnt;

            if (w_state_nxt != r_state)
                r_cnt <= (w_state_nxt == ST_WAIT_FALL) ? CYC_W'(1) : '0;
            else if (r_state inside {ST_TRIG, ST_WAIT_RISE, ST_WAIT_FALL})
                r_cnt <= r_cnt + 1'b1;

            if (w_state_nxt == ST_TRIG && r_state != ST_TRIG)
                r_per <= '0;
            else if (r_per != PERIOD_CYC - 1)
                r_per <= r_per + 1'b1;
        end
    end

    assign o_trig        = (r_state == ST_TRIG);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_echo_cycles = r_echo_cycles;
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_ultrasonic_trig.sv
// Bench for ultrasonic_trig: scenario table plus random echoes, checked against
// an event-timeline model of the measurement cycle, then a reset-in-TRIG sequence.
module tb_ultrasonic_trig;

    localparam int TRIG_C   = 10;
    localparam int PERIOD_C = 2000;
    localparam int RISE_C   = 100;
    localparam int FALL_C   = 500;
    localparam int MAXC     = 60000;
    localparam int CHUNK    = 500;
    localparam int NTBL     = 9;
    localparam int NRND     = 5;

    typedef struct packed {
        logic        trig;
        logic        busy;
        logic        done;
        logic        tmo;
        logic [31:0] ecyc;
    } obs_t;

    typedef struct {
        int dly;       // cycles from trig fall to echo rise, <0 = no echo
        int len;       // echo high cycles
        bit en_off;    // drop enable during the echo
        bit exp_done;
        bit exp_to;
        int exp_w;
        bit chk;       // table row with hand-derived expectations
    } scen_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        echo = 1'b0;
    logic        o_trig, o_busy, o_done, o_timeout;
    logic [31:0] o_echo_cycles;

    logic st_en   [MAXC];
    logic st_echo [MAXC];
    obs_t act     [MAXC];
    obs_t expv    [MAXC];
    bit   upd_v   [MAXC];
    int   upd_w   [MAXC];
    int   n_run = 0;
    int   tot = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ultrasonic_trig #(
        .CLK_PER_US (1),
        .TRIG_US    (TRIG_C),
        .PERIOD_US  (PERIOD_C),
        .RISE_TO_US (RISE_C),
        .FALL_TO_US (FALL_C)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (en),
        .i_echo_in     (echo),
        .o_trig        (o_trig),
        .o_busy        (o_busy),
        .o_echo_cycles (o_echo_cycles),
        .o_done        (o_done),
        .o_timeout     (o_timeout)
    );

    // Echo as seen by the FSM: two cycles late, zero while the synchroniser is in reset.
    function automatic logic es(input int k);
        if (k < 5 || k - 2 >= n_run) return 1'b0;
        return st_echo[k-2];
    endfunction

    function automatic logic en_at(input int k);
        return (k >= 0 && k < n_run) ? st_en[k] : 1'b0;
    endfunction

    // Walk measurement by measurement: trigger window, rise search, width,
    // strobe cycle, then the earliest legal re-trigger.
    task automatic build_model();
        int c, t, wr, r, h, e, n, w;
        for (int k = 0; k < n_run; k++) begin
            expv[k]  = '0;
            upd_v[k] = 1'b0;
            upd_w[k] = 0;
        end
        c = 3;
        t = -1;
        while (c < n_run) begin
            if (t < 0) begin
                if (st_en[c]) t = c + 1;
                c++;
            end else begin
                wr = t + TRIG_C;
                r  = -1;
                for (int k = wr; k < wr + RISE_C; k++)
                    if (r < 0 && es(k)) r = k;
                if (r < 0) begin
                    e = wr + RISE_C;
                    if (e < n_run) expv[e].tmo = 1'b1;
                end else begin
                    h = 0;
                    while (es(r + h)) h++;
                    if (h <= FALL_C) begin
                        e = r + h + 1;
                        if (e < n_run) begin
                            expv[e].done = 1'b1;
                            upd_v[e] = 1'b1;
                            upd_w[e] = h;
                        end
                    end else begin
                        e = r + FALL_C + 1;
                        if (e < n_run) expv[e].tmo = 1'b1;
                    end
                end
                n = (t + PERIOD_C > e + 1) ? t + PERIOD_C : e + 1;
                while (es(n - 1)) n++;
                for (int k = t; k < n && k < n_run; k++) begin
                    expv[k].busy = 1'b1;
                    if (k < wr) expv[k].trig = 1'b1;
                end
                t = en_at(n - 1) ? n : -1;
                c = n;
            end
        end
        w = 0;
        for (int k = 0; k < n_run; k++) begin
            if (upd_v[k]) w = upd_w[k];
            expv[k].ecyc = 32'(w);
        end
    endtask

    task automatic check_trace();
        int bad_at;
        for (int b = 0; b < n_run; b += CHUNK) begin
            bad_at = -1;
            for (int k = b; k < b + CHUNK && k < n_run; k++)
                if (bad_at < 0 && act[k] !== expv[k]) bad_at = k;
            tot++;
            if (bad_at >= 0) begin
                bad++;
                $display("FAIL trace cyc=%0d got trig=%0b busy=%0b done=%0b to=%0b w=%0d want trig=%0b busy=%0b done=%0b to=%0b w=%0d",
                         bad_at, act[bad_at].trig, act[bad_at].busy, act[bad_at].done,
                         act[bad_at].tmo, act[bad_at].ecyc, expv[bad_at].trig,
                         expv[bad_at].busy, expv[bad_at].done, expv[bad_at].tmo,
                         expv[bad_at].ecyc);
            end
        end
    endtask

    initial begin
        scen_t tbl [NTBL];
        scen_t q[$];
        scen_t cs;
        scen_t rs;
        int    c, ps, pe, lo_from, lo_to, last_pop, k, ti;
        logic  prev_trig;
        bit    drained, cur_chk;

        tbl[0] = '{20,  300, 1'b0, 1'b1, 1'b0, 300, 1'b1};
        tbl[1] = '{-1,    0, 1'b0, 1'b0, 1'b1,   0, 1'b1};
        tbl[2] = '{5,  2500, 1'b0, 1'b0, 1'b1,   0, 1'b1};
        tbl[3] = '{30,  500, 1'b0, 1'b1, 1'b0, 500, 1'b1};
        tbl[4] = '{30,  501, 1'b0, 1'b0, 1'b1,   0, 1'b1};
        tbl[5] = '{97,   40, 1'b0, 1'b1, 1'b0,  40, 1'b1};
        tbl[6] = '{98,   40, 1'b0, 1'b0, 1'b1,   0, 1'b1};
        tbl[7] = '{10,    1, 1'b0, 1'b1, 1'b0,   1, 1'b1};
        tbl[8] = '{25,  150, 1'b1, 1'b1, 1'b0, 150, 1'b1};
        for (int i = 0; i < NTBL; i++) q.push_back(tbl[i]);
        for (int i = 0; i < NRND; i++) begin
            rs = '{0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
            rs.dly = int'($urandom_range(120, 0));
            rs.len = int'($urandom_range(700, 1));
            q.push_back(rs);
        end

        cs = '{0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        ps = -1; pe = -1; lo_from = -1; lo_to = -1;
        last_pop = 0; prev_trig = 1'b0; drained = 1'b0; cur_chk = 1'b0; ti = -1;
        c = 0;
        while (c < MAXC && !drained) begin
            @(negedge clk);
            act[c] = {o_trig, o_busy, o_done, o_timeout, o_echo_cycles};
            if (prev_trig && !o_trig) begin
                if (q.size() > 0) begin
                    cs = q.pop_front();
                    ti++;
                    cur_chk  = cs.chk;
                    ps       = (cs.dly < 0) ? -1 : c + cs.dly;
                    pe       = (cs.dly < 0) ? -1 : ps + cs.len;
                    if (cs.en_off) begin
                        lo_from = ps + 50;
                        lo_to   = ps + 2600;
                    end
                    last_pop = c;
                end else begin
                    ps = -1; pe = -1; cur_chk = 1'b0;
                end
            end
            prev_trig = o_trig;
            if ((o_done || o_timeout) && cur_chk) begin
                tot++;
                if (!(o_done == cs.exp_done && o_timeout == cs.exp_to &&
                      (!cs.exp_done || o_echo_cycles == 32'(cs.exp_w)))) begin
                    bad++;
                    $display("FAIL tbl[%0d] got done=%0b to=%0b w=%0d want done=%0b to=%0b w=%0d",
                             ti, o_done, o_timeout, o_echo_cycles, cs.exp_done, cs.exp_to, cs.exp_w);
                end
                cur_chk = 1'b0;
            end
            st_en[c]   = (c >= 8) && !(c >= lo_from && c < lo_to);
            st_echo[c] = (ps >= 0) && (c >= ps) && (c < pe);
            rst  = (c < 2);
            en   = st_en[c];
            echo = st_echo[c];
            if (q.size() == 0 && c > last_pop + 2200) drained = 1'b1;
            c++;
        end
        n_run = c;
        tot++;
        if (!drained) begin
            bad++;
            $display("FAIL run_bound got cycles=%0d want scenarios drained before %0d", c, MAXC);
        end
        build_model();
        check_trace();

        // Reset in the middle of a trigger pulse, then a clean restart.
        k = 0;
        while (!o_trig && k < 3000) begin
            @(negedge clk);
            k++;
        end
        tot++;
        if (!o_trig) begin
            bad++;
            $display("FAIL trig_wait got trig=%0b want 1 within 3000 cycles", o_trig);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tot++;
        if ({o_trig, o_busy, o_done, o_timeout, o_echo_cycles} !== 36'd0) begin
            bad++;
            $display("FAIL rst_mid_trig got trig=%0b busy=%0b done=%0b to=%0b w=%0d want all 0",
                     o_trig, o_busy, o_done, o_timeout, o_echo_cycles);
        end
        rst  = 1'b0;
        en   = 1'b1;
        echo = 1'b0;
        @(negedge clk);
        tot++;
        if (!(o_trig && o_busy)) begin
            bad++;
            $display("FAIL restart_start got trig=%0b busy=%0b want trig=1 busy=1", o_trig, o_busy);
        end
        k = 0;
        while (o_trig && k < 40) begin
            @(negedge clk);
            k++;
        end
        tot++;
        if (k != TRIG_C) begin
            bad++;
            $display("FAIL restart_width got %0d want %0d", k, TRIG_C);
        end
        tot++;
        if (!(o_busy && !o_done && !o_timeout && o_echo_cycles == 32'd0)) begin
            bad++;
            $display("FAIL restart_after got busy=%0b done=%0b to=%0b w=%0d want busy=1 done=0 to=0 w=0",
                     o_busy, o_done, o_timeout, o_echo_cycles);
        end

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
